zap_wb_arbiter: RTL and testbench
=================================

# zap_wb_arbiter

Two-master Wishbone B3 arbiter sharing the core's single memory port between the MMU page-table walker and the cache line-fill/write-back engine. It takes each master's next-cycle (`_nxt`) Wishbone signals, selects one owner per bus cycle, and registers the winner onto the external bus. Ack and read data are routed back only to the current owner. It sits between the cache/TLB subsystem and the top-level Wishbone interface.

## Interface
- Parameters: none.
- `i_clk` in 1: core clock.
- `i_reset` in 1: reset, synchronous, active-high. Clock is `i_clk`.
- `i_m0_cyc_nxt`, `i_m0_stb_nxt`, `i_m0_wen_nxt` in 1 each: walker next-cycle controls.
- `i_m0_sel_nxt` in 4: walker byte selects.
- `i_m0_adr_nxt`, `i_m0_dat_nxt` in 32 each: walker address and write data.
- `o_m0_ack` out 1: ack routed to the walker.
- `o_m0_dat` out 32: read data routed to the walker.
- `i_m1_*_nxt` in: cache-engine next-cycle signals, same set and widths as m0.
- `o_m1_ack` out 1, `o_m1_dat` out 32: ack and read data routed to the cache engine.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_wen` out 1 each: registered bus controls.
- `o_wb_sel` out 4: registered byte selects.
- `o_wb_adr`, `o_wb_dat` out 32 each: registered address and write data.
- `i_wb_dat` in 32: bus read data.
- `i_wb_ack` in 1: bus ack.

## Operation
- States:
  - IDLE: no owner.
  - GNT_M0: walker owns the bus.
  - GNT_M1: cache engine owns the bus.
- IDLE:
  - Only m0 `cyc_nxt`=1: go to GNT_M0.
  - Only m1 `cyc_nxt`=1: go to GNT_M1.
  - Both: winner set by the priority rule (see Configuration).
  - Same edge as the grant: the winner's `_nxt` signals are registered onto `o_wb_*`.
  - Neither: stay in IDLE and register all `o_wb_*` as 0.
- GNT_Mx:
  - Each cycle, register master x's `_nxt` signals onto `o_wb_*`.
  - When master x's `cyc_nxt`=0: register all outputs as 0 and go to IDLE.
  - The losing master is never granted mid-ownership, even when it requests continuously. Burst (multi-beat) cycles from the owner are never split.
- Return path:
  - `o_mx_ack` = `i_wb_ack` & (state==GNT_Mx).
  - `o_mx_dat` = `i_wb_dat` when state==GNT_Mx, else 0.
  - Non-owner ack is always 0.
- Masters hold their `_nxt` requests until they are acked. The arbiter does not latch pending requests.
- Reset in any state: go to IDLE and clear all registered outputs. An in-flight bus cycle is abandoned; the bus slave must accept `cyc` dropping.
- The `i_wb_ack` arriving in the same cycle the owner drops `cyc_nxt` is still routed to the owner, because state is still GNT_Mx.

## Timing
- Reset values:
  - `o_wb_cyc`, `o_wb_stb`, `o_wb_wen` = 0.
  - `o_wb_sel` = 4'h0.
  - `o_wb_adr`, `o_wb_dat` = 32'h0.
  - state = IDLE.
  - `o_m0_ack`, `o_m1_ack` = 0 (combinational from state).
- Request latency: master `cyc_nxt` rises at edge N-1 inputs, so `o_wb_cyc`=1 after edge N. No extra latency over a direct master-to-bus connection.
- Hand-over:
  - The owner's `cyc_nxt` falls, and `o_wb_cyc`=0 for exactly one cycle.
  - A waiting master is granted on the next edge.
  - Minimum one dead bus cycle between owners.
- Ack/data return is combinational, so zero added latency.

## Configuration
- Macro `ZAP_WB_ARB_RR_EN` defined:
  - Round-robin priority. A 1-bit `last_ff` records the most recent owner and updates on every grant.
  - On a simultaneous request in IDLE, the master that was not `last_ff` wins.
  - `last_ff` resets to m1, so m0 wins the first tie.
- Macro undefined: fixed priority, m0 (walker) always wins ties. No `last_ff` flop is present.

## Structure
- The shared defines header holds:
  - State encodings: `ARB_IDLE`=2'd0, `ARB_GNT_M0`=2'd1, `ARB_GNT_M1`=2'd2.
  - Width constants: `WB_ADR_W`=32, `WB_SEL_W`=4.
- One sub-module, `zap_wb_arb_mux`: a combinational 2:1 mux of the `_nxt` bundle, selected by the next owner. The parent keeps the FSM and output flops.
- Two always blocks: combinational next-state/mux, and clocked registers.

## Test plan
- Reset mid-GNT_M1 with `o_wb_cyc`=1, assert `i_reset` 1 cycle -> next cycle state=IDLE, `o_wb_cyc`=0, `o_wb_adr`=0, `o_m1_ack`=0.
- m0 alone reads 0x0000_4008 with sel 4'hF, bus acks 2 cycles later with data 0xDEAD_BEEF -> `o_wb_adr`=0x4008 one cycle after request; `o_m0_ack`=1 and `o_m0_dat`=0xDEADBEEF; `o_m1_ack` stays 0.
- Simultaneous m0/m1 requests from IDLE, fixed priority -> m0 granted first; after m0 drops, one cycle with `o_wb_cyc`=0; then `o_wb_adr` equals m1's address.
- Same stimulus with `ZAP_WB_ARB_RR_EN`, repeated 3 times -> owner order m0, m1, m0, m1, m0, m1.
- m1 4-beat burst (addresses 0x100/0x104/0x108/0x10C) while m0 requests on beat 2 -> all 4 beats complete to m1 uninterrupted; m0 granted only after m1 `cyc_nxt`=0 plus one dead cycle.
- Ack in the same cycle the owner deasserts `cyc_nxt` -> ack routed to the owner; the non-owner sees 0.

Source files
------------

// File: rtl/zap_wb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// State encodings, bus widths and the per-master request bundle.
package zap_wb_arbiter_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_M0 = 2'd1,
    ARB_GNT_M1 = 2'd2
  } arb_state_t;

  // One master's next-cycle Wishbone request.
  typedef struct packed {
    logic                cyc;
    logic                stb;
    logic                wen;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_ADR_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/zap_wb_arb_mux.sv
// Combinational 2:1 select of the masters' next-cycle request bundles.
module zap_wb_arb_mux
  import zap_wb_arbiter_pkg::*;
(
  input  wb_req_t m0,
  input  wb_req_t m1,
  input  logic    sel_m1,
  output wb_req_t req_c
);

  assign req_c = sel_m1 ? m1 : m0;

endmodule

// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone arbiter: page-table walker (m0) and cache engine (m1).
// Define ZAP_WB_ARB_RR_EN for round-robin tie-break; default is fixed m0 priority.
module zap_wb_arbiter
  import zap_wb_arbiter_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_m0_cyc_nxt,
  input  logic                i_m0_stb_nxt,
  input  logic                i_m0_wen_nxt,
  input  logic [WB_SEL_W-1:0] i_m0_sel_nxt,
  input  logic [WB_ADR_W-1:0] i_m0_adr_nxt,
  input  logic [WB_ADR_W-1:0] i_m0_dat_nxt,
  output logic                o_m0_ack,
  output logic [WB_ADR_W-1:0] o_m0_dat,
  input  logic                i_m1_cyc_nxt,
  input  logic                i_m1_stb_nxt,
  input  logic                i_m1_wen_nxt,
  input  logic [WB_SEL_W-1:0] i_m1_sel_nxt,
  input  logic [WB_ADR_W-1:0] i_m1_adr_nxt,
  input  logic [WB_ADR_W-1:0] i_m1_dat_nxt,
  output logic                o_m1_ack,
  output logic [WB_ADR_W-1:0] o_m1_dat,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_wen,
  output logic [WB_SEL_W-1:0] o_wb_sel,
  output logic [WB_ADR_W-1:0] o_wb_adr,
  output logic [WB_ADR_W-1:0] o_wb_dat,
  input  logic [WB_ADR_W-1:0] i_wb_dat,
  input  logic                i_wb_ack
);

  arb_state_t state_ff, state_nxt;
  wb_req_t    m0_req, m1_req, mux_req, wb_nxt;
  logic       sel_m1;

`ifdef ZAP_WB_ARB_RR_EN
  logic last_ff;  // most recent owner: 1 = m1
`endif

  assign m0_req = '{cyc: i_m0_cyc_nxt, stb: i_m0_stb_nxt, wen: i_m0_wen_nxt,
                    sel: i_m0_sel_nxt, adr: i_m0_adr_nxt, dat: i_m0_dat_nxt};
  assign m1_req = '{cyc: i_m1_cyc_nxt, stb: i_m1_stb_nxt, wen: i_m1_wen_nxt,
                    sel: i_m1_sel_nxt, adr: i_m1_adr_nxt, dat: i_m1_dat_nxt};

  zap_wb_arb_mux u_mux (
    .m0     (m0_req),
    .m1     (m1_req),
    .sel_m1 (sel_m1),
    .req_c  (mux_req)
  );

  // Next owner; the bundle of whoever owns the next cycle goes to the bus.
  always_comb begin
    state_nxt = state_ff;
    case (state_ff)
      ARB_IDLE: begin
        if (i_m0_cyc_nxt && i_m1_cyc_nxt) begin
`ifdef ZAP_WB_ARB_RR_EN
          state_nxt = last_ff ? ARB_GNT_M0 : ARB_GNT_M1;
`else
          state_nxt = ARB_GNT_M0;
`endif
        end else if (i_m0_cyc_nxt) begin
          state_nxt = ARB_GNT_M0;
        end else if (i_m1_cyc_nxt) begin
          state_nxt = ARB_GNT_M1;
        end
      end
      ARB_GNT_M0: if (!i_m0_cyc_nxt) state_nxt = ARB_IDLE;
      ARB_GNT_M1: if (!i_m1_cyc_nxt) state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
    sel_m1 = (state_nxt == ARB_GNT_M1);
    wb_nxt = (state_nxt == ARB_IDLE) ? '0 : mux_req;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_ff <= ARB_IDLE;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_wen <= 1'b0;
      o_wb_sel <= '0;
      o_wb_adr <= '0;
      o_wb_dat <= '0;
`ifdef ZAP_WB_ARB_RR_EN
      last_ff  <= 1'b1;
`endif
    end else begin
      state_ff <= state_nxt;
      o_wb_cyc <= wb_nxt.cyc;
      o_wb_stb <= wb_nxt.stb;
      o_wb_wen <= wb_nxt.wen;
      o_wb_sel <= wb_nxt.sel;
      o_wb_adr <= wb_nxt.adr;
      o_wb_dat <= wb_nxt.dat;
`ifdef ZAP_WB_ARB_RR_EN
      if (state_ff == ARB_IDLE && state_nxt != ARB_IDLE)
        last_ff <= (state_nxt == ARB_GNT_M1);
`endif
    end
  end

  // Return path is combinational so the owner sees ack with no added latency.
  assign o_m0_ack = i_wb_ack & (state_ff == ARB_GNT_M0);
  assign o_m1_ack = i_wb_ack & (state_ff == ARB_GNT_M1);
  assign o_m0_dat = (state_ff == ARB_GNT_M0) ? i_wb_dat : '0;
  assign o_m1_dat = (state_ff == ARB_GNT_M1) ? i_wb_dat : '0;

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed self-checking bench for zap_wb_arbiter (either priority build).
module tb_zap_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_wen, m1_cyc, m1_stb, m1_wen;
  logic [3:0]  m0_sel, m1_sel, wb_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdat, m1_rdat;
  logic        wb_cyc, wb_stb, wb_wen;
  logic [31:0] wb_adr, wb_dat, wb_rdat;
  logic        wb_ack;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  zap_wb_arbiter dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_cyc_nxt(m0_cyc), .i_m0_stb_nxt(m0_stb), .i_m0_wen_nxt(m0_wen),
    .i_m0_sel_nxt(m0_sel), .i_m0_adr_nxt(m0_adr), .i_m0_dat_nxt(m0_dat),
    .o_m0_ack(m0_ack), .o_m0_dat(m0_rdat),
    .i_m1_cyc_nxt(m1_cyc), .i_m1_stb_nxt(m1_stb), .i_m1_wen_nxt(m1_wen),
    .i_m1_sel_nxt(m1_sel), .i_m1_adr_nxt(m1_adr), .i_m1_dat_nxt(m1_dat),
    .o_m1_ack(m1_ack), .o_m1_dat(m1_rdat),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_wen(wb_wen),
    .o_wb_sel(wb_sel), .o_wb_adr(wb_adr), .o_wb_dat(wb_dat),
    .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic cyc, input logic [31:0] adr);
    m0_cyc = cyc; m0_stb = cyc; m0_wen = 1'b0; m0_sel = cyc ? 4'hF : 4'h0;
    m0_adr = adr; m0_dat = 32'h0;
  endtask

  task automatic set_m1(input logic cyc, input logic [31:0] adr);
    m1_cyc = cyc; m1_stb = cyc; m1_wen = cyc; m1_sel = cyc ? 4'h3 : 4'h0;
    m1_adr = adr; m1_dat = adr ^ 32'hA5A5_0000;
  endtask

  task automatic test_reset();
    set_m0(1'b0, 32'h0); set_m1(1'b0, 32'h0);
    wb_ack = 1'b1; wb_rdat = 32'h1111_2222;
    rst = 1'b1;
    step(); step();
    total++; if ({wb_cyc, wb_stb, wb_wen} !== 3'b000) $display("FAIL reset_ctl got %b exp 000", {wb_cyc, wb_stb, wb_wen}); else passed++;
    total++; if (wb_sel !== 4'h0) $display("FAIL reset_sel got %h exp 0", wb_sel); else passed++;
    total++; if (wb_adr !== 32'h0 || wb_dat !== 32'h0) $display("FAIL reset_adr_dat got %h/%h exp 0/0", wb_adr, wb_dat); else passed++;
    total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) $display("FAIL reset_acks got %b%b exp 00", m0_ack, m1_ack); else passed++;
    total++; if (m0_rdat !== 32'h0 || m1_rdat !== 32'h0) $display("FAIL reset_rdat got %h/%h exp 0/0", m0_rdat, m1_rdat); else passed++;
    rst = 1'b0; wb_ack = 1'b0; wb_rdat = 32'h0;
  endtask

  task automatic test_reset_mid_grant();
    set_m1(1'b1, 32'h0000_0200);
    step();
    total++; if (wb_cyc !== 1'b1 || wb_adr !== 32'h200) $display("FAIL rmid_grant got cyc=%b adr=%h exp 1/200", wb_cyc, wb_adr); else passed++;
    rst = 1'b1;
    step();
    set_m1(1'b0, 32'h0);
    rst = 1'b0;
    wb_ack = 1'b1;
    #1;
    total++; if (wb_cyc !== 1'b0 || wb_adr !== 32'h0) $display("FAIL rmid_clear got cyc=%b adr=%h exp 0/0", wb_cyc, wb_adr); else passed++;
    total++; if (m1_ack !== 1'b0) $display("FAIL rmid_ack got %b exp 0", m1_ack); else passed++;
    wb_ack = 1'b0;
    step();
  endtask

  task automatic test_m0_read();
    set_m0(1'b1, 32'h0000_4008);
    step();
    total++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_wen !== 1'b0) $display("FAIL m0rd_ctl got %b%b%b exp 110", wb_cyc, wb_stb, wb_wen); else passed++;
    total++; if (wb_adr !== 32'h4008 || wb_sel !== 4'hF) $display("FAIL m0rd_adr got %h/%h exp 4008/f", wb_adr, wb_sel); else passed++;
    step();
    step();
    wb_ack = 1'b1; wb_rdat = 32'hDEAD_BEEF;
    #1;
    total++; if (m0_ack !== 1'b1 || m0_rdat !== 32'hDEAD_BEEF) $display("FAIL m0rd_ack got %b/%h exp 1/deadbeef", m0_ack, m0_rdat); else passed++;
    total++; if (m1_ack !== 1'b0 || m1_rdat !== 32'h0) $display("FAIL m0rd_m1quiet got %b/%h exp 0/0", m1_ack, m1_rdat); else passed++;
    set_m0(1'b0, 32'h0);
    step();
    wb_ack = 1'b0; wb_rdat = 32'h0;
    total++; if (wb_cyc !== 1'b0 || wb_adr !== 32'h0) $display("FAIL m0rd_release got %b/%h exp 0/0", wb_cyc, wb_adr); else passed++;
  endtask

  // Both masters request together from IDLE; the loser waits one dead cycle.
  task automatic test_tie();
    rst = 1'b1; step(); rst = 1'b0;
    set_m0(1'b1, 32'h0000_1000); set_m1(1'b1, 32'h0000_2000);
    step();
    total++; if (wb_adr !== 32'h1000) $display("FAIL tie_first got %h exp 1000", wb_adr); else passed++;
    set_m0(1'b0, 32'h0);
    step();
    total++; if (wb_cyc !== 1'b0) $display("FAIL tie_dead got %b exp 0", wb_cyc); else passed++;
    step();
    total++; if (wb_cyc !== 1'b1 || wb_adr !== 32'h2000 || wb_sel !== 4'h3 || wb_wen !== 1'b1) $display("FAIL tie_second got %b/%h/%h/%b exp 1/2000/3/1", wb_cyc, wb_adr, wb_sel, wb_wen); else passed++;
    total++; if (wb_dat !== 32'hA5A5_2000) $display("FAIL tie_second_dat got %h exp a5a52000", wb_dat); else passed++;
    set_m1(1'b0, 32'h0);
    step();
  endtask

  // Six consecutive ties; each owner drops after one beat and re-requests.
  task automatic test_tie_repeat();
    logic [31:0] exp_adr [6];
`ifdef ZAP_WB_ARB_RR_EN
    exp_adr = '{32'h1000, 32'h2000, 32'h1000, 32'h2000, 32'h1000, 32'h2000};
`else
    exp_adr = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000};
`endif
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_m0(1'b1, 32'h0000_1000); set_m1(1'b1, 32'h0000_2000);
      step();
      total++; if (wb_adr !== exp_adr[i]) $display("FAIL tie_rep%0d got %h exp %h", i, wb_adr, exp_adr[i]); else passed++;
      if (wb_adr == 32'h2000) set_m1(1'b0, 32'h0); else set_m0(1'b0, 32'h0);
      step();
    end
    set_m0(1'b0, 32'h0); set_m1(1'b0, 32'h0);
    step();
  endtask

  task automatic test_burst();
    set_m1(1'b1, 32'h0000_0100);
    step();
    total++; if (wb_adr !== 32'h100) $display("FAIL burst_b0 got %h exp 100", wb_adr); else passed++;
    wb_ack = 1'b1;
    set_m0(1'b1, 32'h0000_3000);
    for (int b = 1; b < 4; b++) begin
      set_m1(1'b1, 32'h100 + 32'(4 * b));
      step();
      total++; if (wb_cyc !== 1'b1 || wb_adr !== 32'h100 + 32'(4 * b)) $display("FAIL burst_b%0d got %b/%h exp 1/%h", b, wb_cyc, wb_adr, 32'h100 + 32'(4 * b)); else passed++;
      total++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) $display("FAIL burst_ack%0d got m1=%b m0=%b exp 1/0", b, m1_ack, m0_ack); else passed++;
    end
    set_m1(1'b0, 32'h0);
    step();
    wb_ack = 1'b0;
    total++; if (wb_cyc !== 1'b0) $display("FAIL burst_dead got %b exp 0", wb_cyc); else passed++;
    step();
    total++; if (wb_cyc !== 1'b1 || wb_adr !== 32'h3000) $display("FAIL burst_m0 got %b/%h exp 1/3000", wb_cyc, wb_adr); else passed++;
    set_m0(1'b0, 32'h0);
    step();
  endtask

  task automatic test_ack_on_drop();
    set_m1(1'b1, 32'h0000_0500);
    step();
    set_m1(1'b0, 32'h0);
    wb_ack = 1'b1; wb_rdat = 32'h0000_1234;
    #1;
    total++; if (m1_ack !== 1'b1 || m1_rdat !== 32'h1234) $display("FAIL drop_ack got %b/%h exp 1/1234", m1_ack, m1_rdat); else passed++;
    total++; if (m0_ack !== 1'b0 || m0_rdat !== 32'h0) $display("FAIL drop_nonowner got %b/%h exp 0/0", m0_ack, m0_rdat); else passed++;
    step();
    total++; if (wb_cyc !== 1'b0 || m1_ack !== 1'b0) $display("FAIL drop_idle got cyc=%b ack=%b exp 0/0", wb_cyc, m1_ack); else passed++;
    wb_ack = 1'b0; wb_rdat = 32'h0;
  endtask

  initial begin
    rst = 1'b1; wb_ack = 1'b0; wb_rdat = 32'h0;
    test_reset();
    test_reset_mid_grant();
    test_m0_read();
    test_tie();
    test_tie_repeat();
    test_burst();
    test_ack_on_drop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
